izhikevich_array: RTL and testbench

Time-multiplexed array of N Izhikevich neurons sharing one datapath. It is the parametrised successor of the single-neuron core and sits between the synapse/current-injection logic and the spike router. Each integration step is started by an internal clock-divider tick. On each step the block sweeps every neuron once, updates v/u in saturating fixed point, and emits one spike event per firing neuron. Per-neuron parameters and input currents are runtime-writable, and neuron state is readable for debug.

---
 rtl/izhikevich_array.sv | 211 +++++++++++++++++++++
 tb/tb_izhikevich_array.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/izhikevich_array.sv
// Time-multiplexed array of N Izhikevich neurons sharing one saturating Q2.(W-2)
// datapath; every divider tick sweeps all neurons once and emits their spike events.
module izhikevich_array #(
   parameter  int N        = 8,
   parameter  int W        = 18,
   parameter  int DT_SHIFT = 4,
   parameter  int TICK_DIV = 4096,
   localparam int NW       = (N > 1) ? $clog2(N) : 1
) (
   input  logic          CLOCK_50,
   input  logic          reset,
   input  logic          cfg_we,
   input  logic [NW-1:0] cfg_addr,
   input  logic [2:0]    cfg_sel,
   input  logic [W-1:0]  cfg_data,
   input  logic [NW-1:0] rd_addr,
   output logic [W-1:0]  rd_v,
   output logic [W-1:0]  rd_u,
   output logic          spike_valid,
   output logic [NW-1:0] spike_id,
   output logic          step_done,
   output logic          busy,
   output logic          overrun
);
   localparam int     FRAC = W - 2;
   localparam int     WX   = W + 4;
   localparam int     CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam longint ONE  = longint'(1) << FRAC;

   typedef logic signed [W-1:0]   word_t;
   typedef logic signed [WX-1:0]  wide_t;
   typedef logic signed [2*W-1:0] dbl_t;
   typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

   // Decimal constants rounded to the nearest LSB of the Q2.FRAC format.
   localparam word_t V_RST    = word_t'(-((65 * ONE + 50) / 100));
   localparam word_t U_RST    = word_t'((20 * ONE + 50) / 100);
   localparam word_t A_RST    = word_t'((2 * ONE + 50) / 100);
   localparam word_t B_RST    = word_t'((20 * ONE + 50) / 100);
   localparam word_t C_RST    = word_t'(-(ONE / 2));
   localparam word_t D_RST    = word_t'((2 * ONE + 50) / 100);
   localparam word_t P_RST    = word_t'((30 * ONE + 50) / 100);
   localparam word_t K_CONST  = word_t'((35 * ONE + 50) / 100);
   localparam word_t WORD_MAX = {1'b0, {(W-1){1'b1}}};
   localparam word_t WORD_MIN = {1'b1, {(W-1){1'b0}}};

   function automatic word_t sat_wide(input wide_t x);
      if (x[WX-1:W-1] == '0 || x[WX-1:W-1] == '1) return x[W-1:0];
      return x[WX-1] ? WORD_MIN : WORD_MAX;
   endfunction

   function automatic word_t mul(input word_t x, input word_t y);
      dbl_t prod;
      prod = dbl_t'(x) * dbl_t'(y);
      prod = prod >>> FRAC;
      if (prod[2*W-1:W-1] == '0 || prod[2*W-1:W-1] == '1) return prod[W-1:0];
      return prod[2*W-1] ? WORD_MIN : WORD_MAX;
   endfunction

   word_t v_q [N], v_d [N], u_q [N], u_d [N];
   word_t a_q [N], a_d [N], b_q [N], b_d [N], c_q [N], c_d [N];
   word_t d_q [N], d_d [N], p_q [N], p_d [N], i_q [N], i_d [N];
   word_t rd_v_q, rd_v_d, rd_u_q, rd_u_d;

   state_t          state_q, state_d;
   logic [NW-1:0]   idx_q, idx_d, spike_id_q, spike_id_d;
   logic [CW-1:0]   div_q, div_d;
   logic            busy_q, busy_d, step_done_q, step_done_d;
   logic            spike_valid_q, spike_valid_d, overrun_q, overrun_d;
   logic            tick, fire;
   word_t           v_cur, u_cur, bv_u, v_new, u_new;
   wide_t           dv, du;

   // Datapath for the neuron selected by idx_q; the bracketed (b*v - u) is
   // clamped to W bits before it feeds the second multiplier.
   always_comb begin
      v_cur = v_q[idx_q];
      u_cur = u_q[idx_q];
      fire  = v_cur > p_q[idx_q];
      dv    = wide_t'(mul(v_cur, v_cur)) + wide_t'(v_cur) + wide_t'(v_cur >>> 2)
              + wide_t'(K_CONST) - wide_t'(u_cur >>> 2) + wide_t'(i_q[idx_q] >>> 2);
      bv_u  = sat_wide(wide_t'(mul(b_q[idx_q], v_cur)) - wide_t'(u_cur));
      du    = wide_t'(mul(a_q[idx_q], bv_u)) >>> DT_SHIFT;
      if (fire) begin
         v_new = c_q[idx_q];
         u_new = sat_wide(wide_t'(u_cur) + wide_t'(d_q[idx_q]));
      end else begin
         v_new = sat_wide(wide_t'(v_cur) + (dv >>> (DT_SHIFT - 2)));
         u_new = sat_wide(wide_t'(u_cur) + du);
      end
   end

   // Config writes only touch parameter arrays, so a write aimed at the neuron
   // being swept cannot disturb its current update.
   always_comb begin
      v_d = v_q;
      u_d = u_q;
      a_d = a_q;
      b_d = b_q;
      c_d = c_q;
      d_d = d_q;
      p_d = p_q;
      i_d = i_q;
      if (state_q == S_SWEEP) begin
         v_d[idx_q] = v_new;
         u_d[idx_q] = u_new;
      end
      if (cfg_we && (int'(cfg_addr) < N)) begin
         case (cfg_sel)
            3'd0:    a_d[cfg_addr] = cfg_data;
            3'd1:    b_d[cfg_addr] = cfg_data;
            3'd2:    c_d[cfg_addr] = cfg_data;
            3'd3:    d_d[cfg_addr] = cfg_data;
            3'd4:    p_d[cfg_addr] = cfg_data;
            3'd5:    i_d[cfg_addr] = cfg_data;
            default: ;
         endcase
      end
      rd_v_d = (int'(rd_addr) < N) ? v_q[rd_addr] : '0;
      rd_u_d = (int'(rd_addr) < N) ? u_q[rd_addr] : '0;
   end

   always_comb begin
      tick          = (div_q == CW'(TICK_DIV - 1));
      div_d         = tick ? '0 : div_q + CW'(1);
      state_d       = state_q;
      idx_d         = idx_q;
      busy_d        = busy_q;
      step_done_d   = 1'b0;
      spike_valid_d = 1'b0;
      spike_id_d    = '0;
      overrun_d     = overrun_q | (tick && (state_q != S_IDLE));
      case (state_q)
         S_IDLE: begin
            if (tick) begin
               state_d = S_SWEEP;
               idx_d   = '0;
               busy_d  = 1'b1;
            end
         end
         S_SWEEP: begin
            spike_valid_d = fire;
            spike_id_d    = fire ? idx_q : '0;
            if (idx_q == NW'(N - 1)) begin
               state_d     = S_DONE;
               step_done_d = 1'b1;
            end else begin
               idx_d = idx_q + NW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         div_q         <= '0;
         busy_q        <= 1'b0;
         step_done_q   <= 1'b0;
         spike_valid_q <= 1'b0;
         spike_id_q    <= '0;
         overrun_q     <= 1'b0;
         rd_v_q        <= '0;
         rd_u_q        <= '0;
         for (int n = 0; n < N; n++) begin
            v_q[n] <= V_RST;
            u_q[n] <= U_RST;
            a_q[n] <= A_RST;
            b_q[n] <= B_RST;
            c_q[n] <= C_RST;
            d_q[n] <= D_RST;
            p_q[n] <= P_RST;
            i_q[n] <= '0;
         end
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         div_q         <= div_d;
         busy_q        <= busy_d;
         step_done_q   <= step_done_d;
         spike_valid_q <= spike_valid_d;
         spike_id_q    <= spike_id_d;
         overrun_q     <= overrun_d;
         rd_v_q        <= rd_v_d;
         rd_u_q        <= rd_u_d;
         v_q           <= v_d;
         u_q           <= u_d;
         a_q           <= a_d;
         b_q           <= b_d;
         c_q           <= c_d;
         d_q           <= d_d;
         p_q           <= p_d;
         i_q           <= i_d;
      end
   end

   assign rd_v        = rd_v_q;
   assign rd_u        = rd_u_q;
   assign spike_valid = spike_valid_q;
   assign spike_id    = spike_id_q;
   assign step_done   = step_done_q;
   assign busy        = busy_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_izhikevich_array.sv
// Bench for izhikevich_array: a 4-neuron instance checked step by step against a
// plain-arithmetic neuron model, plus an 8-neuron fast-tick instance for overrun.
module tb_izhikevich_array;
   localparam int N   = 4;
   localparam int W   = 18;
   localparam int NW  = 2;
   localparam int TD  = 64;
   localparam int NO  = 8;
   localparam int NWO = 3;
   localparam int TDO = 4;

   logic CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   logic          reset, cfg_we;
   logic [NW-1:0] cfg_addr, rd_addr;
   logic [2:0]    cfg_sel;
   logic [W-1:0]  cfg_data;
   logic [W-1:0]  rd_v, rd_u;
   logic          spike_valid, step_done, busy, overrun;
   logic [NW-1:0] spike_id;

   logic           reset_o;
   logic           cfg_we_o   = 1'b0;
   logic [NWO-1:0] cfg_addr_o = '0;
   logic [NWO-1:0] rd_addr_o  = '0;
   logic [2:0]     cfg_sel_o  = '0;
   logic [W-1:0]   cfg_data_o = '0;
   logic [W-1:0]   rd_v_o, rd_u_o;
   logic           spike_valid_o, step_done_o, busy_o, overrun_o;
   logic [NWO-1:0] spike_id_o;

   izhikevich_array #(.N(N), .W(W), .DT_SHIFT(4), .TICK_DIV(TD)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_sel(cfg_sel), .cfg_data(cfg_data), .rd_addr(rd_addr), .rd_v(rd_v),
      .rd_u(rd_u), .spike_valid(spike_valid), .spike_id(spike_id),
      .step_done(step_done), .busy(busy), .overrun(overrun)
   );

   izhikevich_array #(.N(NO), .W(W), .DT_SHIFT(4), .TICK_DIV(TDO)) dut_ovr (
      .CLOCK_50(CLOCK_50), .reset(reset_o), .cfg_we(cfg_we_o), .cfg_addr(cfg_addr_o),
      .cfg_sel(cfg_sel_o), .cfg_data(cfg_data_o), .rd_addr(rd_addr_o), .rd_v(rd_v_o),
      .rd_u(rd_u_o), .spike_valid(spike_valid_o), .spike_id(spike_id_o),
      .step_done(step_done_o), .busy(busy_o), .overrun(overrun_o)
   );

   int errors = 0;
   int checks = 0;
   logic [NW-1:0] exp_q[$];
   int mv[N], mu[N], ma[N], mb[N], mc[N], md[N], mp[N], mi[N];
   int last_v2;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge CLOCK_50);
   endtask

   // Reference neuron model: the update equations in plain integer arithmetic.
   function automatic int sat(input longint x);
      if (x > 131071) return 131071;
      if (x < -131072) return -131072;
      return int'(x);
   endfunction

   function automatic int mul(input int x, input int y);
      return sat((longint'(x) * longint'(y)) >>> 16);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mv[i] = -42598; mu[i] = 13107; ma[i] = 1311; mb[i] = 13107;
         mc[i] = -32768; md[i] = 1311;  mp[i] = 19661; mi[i] = 0;
      end
   endtask

   task automatic model_step();
      longint dv;
      int nv, nu;
      for (int i = 0; i < N; i++) begin
         if (mv[i] > mp[i]) begin
            exp_q.push_back(NW'(i));
            nv = mc[i];
            nu = sat(longint'(mu[i]) + md[i]);
         end else begin
            dv = longint'(mul(mv[i], mv[i])) + mv[i] + (mv[i] >>> 2) + 22938
                 - (mu[i] >>> 2) + (mi[i] >>> 2);
            nv = sat(longint'(mv[i]) + (dv >>> 2));
            nu = sat(longint'(mu[i]) +
                     (longint'(mul(ma[i], sat(longint'(mul(mb[i], mv[i])) - mu[i]))) >>> 4));
         end
         mv[i] = nv;
         mu[i] = nu;
      end
   endtask

   task automatic model_write(input int addr, input int sel, input int data);
      case (sel)
         0: ma[addr] = data;
         1: mb[addr] = data;
         2: mc[addr] = data;
         3: md[addr] = data;
         4: mp[addr] = data;
         5: mi[addr] = data;
         default: ;
      endcase
   endtask

   task automatic cfg_write(input int addr, input int sel, input int data);
      cfg_we = 1'b1; cfg_addr = NW'(addr); cfg_sel = 3'(sel); cfg_data = W'(data);
      cyc();
      cfg_we = 1'b0;
      model_write(addr, sel, data);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(); cyc();
      check("rst_spike_valid", spike_valid, 0);
      check("rst_spike_id", spike_id, 0);
      check("rst_step_done", step_done, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_rd_v_out", rd_v, 0);
      check("rst_rd_u_out", rd_u, 0);
      reset = 1'b0; rd_addr = '0;
      model_reset();
      cyc();
      check("rst_v0", $signed(rd_v), -42598);
      check("rst_u0", $signed(rd_u), 13107);
   endtask

   task automatic wait_busy(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 4 * TD; n++) begin
         cyc();
         if (busy === 1'b1) begin ok = 1'b1; break; end
      end
      if (!ok) check("busy_timeout", busy, 1);
   endtask

   // Drives one sweep: spike events must come in cycles T+2..T+N+1 in id order.
   task automatic run_step(input bit col, input int caddr, input int csel, input int cdata,
                           output logic [N-1:0] mask);
      bit ok, e;
      mask = '0;
      wait_busy(ok);
      if (!ok) return;
      exp_q.delete();
      model_step();
      for (int k = 0; k < N; k++) begin
         cyc();
         if (col && k == 0) begin
            cfg_we = 1'b1; cfg_addr = NW'(caddr); cfg_sel = 3'(csel); cfg_data = W'(cdata);
         end
         if (k == 1) cfg_we = 1'b0;
         e = (exp_q.size() > 0) && (exp_q[0] == NW'(k));
         check("spike_valid", spike_valid, e);
         if (spike_valid === 1'b1) mask[spike_id] = 1'b1;
         if (e) check("spike_id", spike_id, exp_q.pop_front());
         check("step_done", step_done, (k == N - 1));
      end
      check("busy_in_done", busy, 1);
      cyc();
      check("busy_after", busy, 0);
      if (col) model_write(caddr, csel, cdata);
   endtask

   task automatic read_nrn(input int i, output int v, output int u);
      rd_addr = NW'(i);
      cyc();
      v = int'($signed(rd_v));
      u = int'($signed(rd_u));
   endtask

   task automatic check_state();
      int v, u;
      for (int i = 0; i < N; i++) begin
         read_nrn(i, v, u);
         check($sformatf("v[%0d]", i), v, mv[i]);
         check($sformatf("u[%0d]", i), u, mu[i]);
         if (i == 2) last_v2 = v;
      end
   endtask

   initial begin
      logic [N-1:0] mask;
      int  tv, tu, prev_v2, done_at, busy_at10;
      bit  ok, sat_seen, spk_after, wrapped, seen;
      reset = 1'b1; reset_o = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_sel = '0;
      cfg_data = '0; rd_addr = '0;

      do_reset();
      run_step(0, 0, 0, 0, mask);
      check("quiet_mask", mask, 0);
      check_state();

      do_reset();
      for (int i = 0; i < N; i++) cfg_write(i, 4, -45875);
      run_step(0, 0, 0, 0, mask);
      check("forced_mask", mask, 4'hF);
      check_state();
      read_nrn(3, tv, tu);
      check("forced_v3", tv, -32768);
      check("forced_u3", tu, 14418);

      do_reset();
      run_step(1, 1, 4, -45875, mask);
      check("col_old_p", mask[1], 0);
      check_state();
      run_step(0, 0, 0, 0, mask);
      check("col_new_p", mask[1], 1);
      check_state();

      do_reset();
      cfg_write(2, 5, 131006);
      cfg_write(2, 4, 131070);
      sat_seen = 0; spk_after = 0; wrapped = 0; prev_v2 = -42598;
      for (int s = 0; s < 30 && !spk_after; s++) begin
         run_step(0, 0, 0, 0, mask);
         check_state();
         if (sat_seen && mask[2]) spk_after = 1;
         if (!mask[2] && prev_v2 > 0 && last_v2 < prev_v2) wrapped = 1;
         if (last_v2 == 131071) sat_seen = 1;
         prev_v2 = last_v2;
      end
      check("sat_reached", sat_seen, 1);
      check("sat_then_spike", spk_after, 1);
      check("sat_no_wrap", wrapped, 0);

      do_reset();
      for (int s = 0; s < 6; s++) begin
         for (int w = 0; w < 3; w++)
            cfg_write($urandom_range(N - 1, 0), $urandom_range(7, 0),
                      int'($urandom_range(262143, 0)) - 131072);
         run_step(0, 0, 0, 0, mask);
         check_state();
      end

      wait_busy(ok);
      cyc(); cyc();
      reset = 1'b1;
      cyc(); cyc();
      check("abort_busy", busy, 0);
      check("abort_spike", spike_valid, 0);
      check("abort_done", step_done, 0);
      reset = 1'b0;
      model_reset();
      seen = 0;
      for (int n = 0; n < 2 * N + 4; n++) begin
         cyc();
         if (step_done !== 1'b0 || spike_valid !== 1'b0) seen = 1;
      end
      check("abort_quiet", seen, 0);
      check_state();
      run_step(0, 0, 0, 0, mask);
      check("abort_next_mask", mask, 0);
      check_state();

      reset_o = 1'b0;
      for (int n = 0; n < 20; n++) begin
         cyc();
         if (busy_o === 1'b1) break;
      end
      check("ovr_busy", busy_o, 1);
      check("ovr_clear_t1", overrun_o, 0);
      cyc(); cyc(); cyc();
      check("ovr_clear_t4", overrun_o, 0);
      cyc();
      check("ovr_set_t5", overrun_o, 1);
      done_at = -1; busy_at10 = -1;
      for (int off = 6; off <= 12; off++) begin
         cyc();
         if (step_done_o === 1'b1 && done_at < 0) done_at = off;
         if (off == 10) busy_at10 = int'(busy_o);
      end
      check("ovr_done_cycle", done_at, 9);
      check("ovr_idle_t10", busy_at10, 0);
      for (int n = 0; n < 30; n++) cyc();
      check("ovr_sticky", overrun_o, 1);
      reset_o = 1'b1;
      cyc(); cyc();
      check("ovr_reset_clear", overrun_o, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
